pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter sequencer with return-address stack
//
// Purpose:
//   Holds the fetch PC and chooses its next value each cycle from the
//   downstream incrementer result, a branch target, a jump/call target, or
//   the top of a small return-address stack. A one-cycle BOOT state follows
//   reset, and any stack overflow or underflow parks the unit in FAULT until
//   the next reset.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   pc_plus_one    pc + 1 from the external incrementer (wraps 1023 -> 0)
//   stall          freeze pc, stack, stack_count and state this cycle
//   branch_taken   load branch_target
//   branch_target  branch destination
//   jump           load jump_target
//   call           push pc_plus_one, then load jump_target
//   jump_target    jump/call destination
//   ret            pop the stack top into pc
//   pc             registered current PC (feeds the incrementer)
//   pc_valid       pc holds a fetchable address (RUN state)
//   fault          sticky overflow/underflow indication (FAULT state)
//   stack_count    return-address stack occupancy, 0..STACK_DEPTH
//
// Parameters:
//   RESET_VECTOR   PC loaded on reset
//   STACK_DEPTH    return-address stack entries, legal range 2..8

module pc_fetch_unit #(
    parameter logic [9:0] RESET_VECTOR = 10'd0,
    parameter int         STACK_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] pc_plus_one,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [9:0] branch_target,
    input  logic       jump,
    input  logic       call,
    input  logic [9:0] jump_target,
    input  logic       ret,
    output logic [9:0] pc,
    output logic       pc_valid,
    output logic       fault,
    output logic [3:0] stack_count
);

    localparam int         AW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] DEPTH4 = 4'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [9:0]    pc_d;
    logic [3:0]    count_d;
    logic          push_en;
    logic          stack_full;
    logic          stack_empty;
    logic [3:0]    count_dec;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;

    // Return addresses; entries at or above stack_count are stale and never
    // observed, so the array carries no reset.
    logic [9:0]    stack_mem [STACK_DEPTH];

    assign stack_full  = (stack_count == DEPTH4);
    assign stack_empty = (stack_count == 4'd0);
    assign count_dec   = stack_count - 4'd1;
    // Indices are only used when the access is legal (push when not full,
    // pop when not empty), so the truncated slices always land in range.
    assign push_idx    = stack_count[AW-1:0];
    assign pop_idx     = count_dec[AW-1:0];

    // Next-state / next-PC selection. Requests are examined in strict
    // priority order; anything below the winner is simply dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        count_d = stack_count;
        push_en = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // pc already sits at RESET_VECTOR; stall stretches BOOT.
                if (!stall) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (stall) begin
                    // hold everything, including would-be faulting requests
                end else if (ret) begin
                    if (stack_empty) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = stack_mem[pop_idx];
                        count_d = count_dec;
                    end
                end else if (call) begin
                    if (stack_full) begin
                        state_d = ST_FAULT;
                    end else begin
                        push_en = 1'b1;
                        pc_d    = jump_target;
                        count_d = stack_count + 4'd1;
                    end
                end else if (jump) begin
                    pc_d = jump_target;
                end else if (branch_taken) begin
                    pc_d = branch_target;
                end else begin
                    // Wrap at 1023 comes from the incrementer itself.
                    pc_d = pc_plus_one;
                end
            end

            ST_FAULT: begin
                // terminal until reset
            end

            default: begin
                // An unreachable encoding is treated as a fault.
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_BOOT;
            pc          <= RESET_VECTOR;
            stack_count <= 4'd0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            stack_count <= count_d;
        end
    end

    // push_en is low whenever reset is asserted because state is BOOT.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= pc_plus_one;
        end
    end

    // Decoded straight from the state register so reset clears them
    // without waiting for a clock.
    assign pc_valid = (state_q == ST_RUN);
    assign fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit

module tb_pc_fetch_unit;

    logic       clk;
    logic       reset_n;
    logic [9:0] pc_plus_one;
    logic       stall;
    logic       branch_taken;
    logic [9:0] branch_target;
    logic       jump;
    logic       call;
    logic [9:0] jump_target;
    logic       ret;
    logic [9:0] pc;
    logic       pc_valid;
    logic       fault;
    logic [3:0] stack_count;

    int checks;
    int failures;

    pc_fetch_unit #(
        .RESET_VECTOR (10'd0),
        .STACK_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_plus_one   (pc_plus_one),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .fault         (fault),
        .stack_count   (stack_count)
    );

    // Incrementer stage model.
    assign pc_plus_one = pc + 10'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
        branch_target = 10'd0; jump_target = 10'd0;
    endtask

    task automatic test_reset();
        clear_req();
        reset_n = 0;
        tick();
        checks++; if (pc !== 10'd0) begin failures++; $display("FAIL rst_pc: got %0d expected 0", pc); end
        checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", pc_valid); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %0b expected 0", fault); end
        checks++; if (stack_count !== 4'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", stack_count); end
        reset_n = 1;
        checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL boot_valid: got %0b expected 0", pc_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== 10'(i)) begin failures++; $display("FAIL seq_pc[%0d]: got %0d expected %0d", i, pc, i); end
            checks++; if (pc_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d]: got %0b expected 1", i, pc_valid); end
        end
    endtask

    task automatic test_priority();
        tick(); tick();
        checks++; if (pc !== 10'd5) begin failures++; $display("FAIL prio_start: got %0d expected 5", pc); end
        branch_taken = 1; branch_target = 10'd100; jump = 1; jump_target = 10'd200;
        tick();
        clear_req();
        checks++; if (pc !== 10'd200) begin failures++; $display("FAIL prio_jump: got %0d expected 200", pc); end
        tick();
        checks++; if (pc !== 10'd201) begin failures++; $display("FAIL prio_next: got %0d expected 201", pc); end
    endtask

    task automatic test_call_ret();
        jump = 1; jump_target = 10'd10;
        tick();
        clear_req();
        checks++; if (pc !== 10'd10) begin failures++; $display("FAIL cr_start: got %0d expected 10", pc); end
        call = 1; jump_target = 10'd300;
        tick();
        clear_req();
        checks++; if (pc !== 10'd300) begin failures++; $display("FAIL cr_call_pc: got %0d expected 300", pc); end
        checks++; if (stack_count !== 4'd1) begin failures++; $display("FAIL cr_call_cnt: got %0d expected 1", stack_count); end
        tick();
        checks++; if (pc !== 10'd301) begin failures++; $display("FAIL cr_301: got %0d expected 301", pc); end
        ret = 1;
        tick();
        clear_req();
        checks++; if (pc !== 10'd11) begin failures++; $display("FAIL cr_ret_pc: got %0d expected 11", pc); end
        checks++; if (stack_count !== 4'd0) begin failures++; $display("FAIL cr_ret_cnt: got %0d expected 0", stack_count); end
        tick();
        checks++; if (pc !== 10'd12) begin failures++; $display("FAIL cr_after: got %0d expected 12", pc); end
    endtask

    task automatic test_overflow();
        logic [9:0] tgt [4];
        tgt[0] = 10'd50; tgt[1] = 10'd60; tgt[2] = 10'd70; tgt[3] = 10'd80;
        for (int i = 0; i < 4; i++) begin
            call = 1; jump_target = tgt[i];
            tick();
            clear_req();
            checks++; if (pc !== tgt[i]) begin failures++; $display("FAIL ov_call_pc[%0d]: got %0d expected %0d", i, pc, tgt[i]); end
            checks++; if (stack_count !== 4'(i + 1)) begin failures++; $display("FAIL ov_call_cnt[%0d]: got %0d expected %0d", i, stack_count, i + 1); end
        end
        // ret outranks call even when the stack is full: pops 71 pushed at pc=70
        call = 1; ret = 1; jump_target = 10'd99;
        tick();
        clear_req();
        checks++; if (pc !== 10'd71) begin failures++; $display("FAIL ov_retcall_pc: got %0d expected 71", pc); end
        checks++; if (stack_count !== 4'd3) begin failures++; $display("FAIL ov_retcall_cnt: got %0d expected 3", stack_count); end
        call = 1; jump_target = 10'd80;
        tick();
        clear_req();
        checks++; if (stack_count !== 4'd4) begin failures++; $display("FAIL ov_refill_cnt: got %0d expected 4", stack_count); end
        call = 1; jump_target = 10'd90;
        tick();
        clear_req();
        checks++; if (pc !== 10'd80) begin failures++; $display("FAIL ov_pc: got %0d expected 80", pc); end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL ov_fault: got %0b expected 1", fault); end
        checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL ov_valid: got %0b expected 0", pc_valid); end
        checks++; if (stack_count !== 4'd4) begin failures++; $display("FAIL ov_cnt: got %0d expected 4", stack_count); end
        jump = 1; jump_target = 10'd5; ret = 1; branch_taken = 1; branch_target = 10'd6;
        tick(); tick();
        clear_req();
        checks++; if (pc !== 10'd80) begin failures++; $display("FAIL ov_ignore_pc: got %0d expected 80", pc); end
        checks++; if (stack_count !== 4'd4) begin failures++; $display("FAIL ov_ignore_cnt: got %0d expected 4", stack_count); end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL ov_ignore_fault: got %0b expected 1", fault); end
        reset_n = 0;
        #2;
        checks++; if (pc !== 10'd0) begin failures++; $display("FAIL ov_rst_pc: got %0d expected 0", pc); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL ov_rst_fault: got %0b expected 0", fault); end
        checks++; if (stack_count !== 4'd0) begin failures++; $display("FAIL ov_rst_cnt: got %0d expected 0", stack_count); end
        tick();
        reset_n = 1;
        tick();
        checks++; if (pc_valid !== 1'b1 || pc !== 10'd0) begin failures++; $display("FAIL ov_reboot: got pc=%0d valid=%0b expected pc=0 valid=1", pc, pc_valid); end
    endtask

    task automatic test_underflow();
        stall = 1; ret = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (fault !== 1'b0) begin failures++; $display("FAIL uf_stall_fault[%0d]: got %0b expected 0", i, fault); end
            checks++; if (pc !== 10'd0) begin failures++; $display("FAIL uf_stall_pc[%0d]: got %0d expected 0", i, pc); end
        end
        stall = 0;
        tick();
        clear_req();
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL uf_fault: got %0b expected 1", fault); end
        checks++; if (pc !== 10'd0 || stack_count !== 4'd0) begin failures++; $display("FAIL uf_hold: got pc=%0d cnt=%0d expected pc=0 cnt=0", pc, stack_count); end
        stall = 1;
        reset_n = 0;
        #2;
        checks++; if (fault !== 1'b0 || pc_valid !== 1'b0) begin failures++; $display("FAIL uf_rst: got fault=%0b valid=%0b expected 0 0", fault, pc_valid); end
        tick();
        reset_n = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL boot_stall[%0d]: got %0b expected 0", i, pc_valid); end
        end
        stall = 0;
        tick();
        checks++; if (pc_valid !== 1'b1 || pc !== 10'd0) begin failures++; $display("FAIL boot_exit: got pc=%0d valid=%0b expected pc=0 valid=1", pc, pc_valid); end
        tick();
        checks++; if (pc !== 10'd1) begin failures++; $display("FAIL boot_seq: got %0d expected 1", pc); end
    endtask

    task automatic test_wrap_stall();
        jump = 1; jump_target = 10'd1023;
        tick();
        clear_req();
        checks++; if (pc !== 10'd1023) begin failures++; $display("FAIL wrap_top: got %0d expected 1023", pc); end
        tick();
        checks++; if (pc !== 10'd0) begin failures++; $display("FAIL wrap_zero: got %0d expected 0", pc); end
        jump = 1; jump_target = 10'd7;
        tick();
        clear_req();
        stall = 1; call = 1; jump_target = 10'd300;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 10'd7) begin failures++; $display("FAIL stall_pc[%0d]: got %0d expected 7", i, pc); end
            checks++; if (stack_count !== 4'd0) begin failures++; $display("FAIL stall_cnt[%0d]: got %0d expected 0", i, stack_count); end
        end
        clear_req();
        tick();
        checks++; if (pc !== 10'd8 || stack_count !== 4'd0) begin failures++; $display("FAIL stall_release: got pc=%0d cnt=%0d expected pc=8 cnt=0", pc, stack_count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 0;
        clear_req();
        test_reset();
        test_priority();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wrap_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
